// File: rtl/stream_parity_unit.sv
// stream_parity_unit: pipelined per-word parity generator/checker for a
// valid/ready word stream framed by a last flag. Packet parity, beat count
// and error status are reported alongside the last beat of each packet.
// Optional statistics counters are built when PARITY_STATS_EN is defined.
module stream_parity_unit #(
   parameter int DATA_W     = 8,
   parameter int ODD_PARITY = 0,
   parameter int MAX_BEATS  = 16,
   localparam int CW        = $clog2(MAX_BEATS + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_par,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_par,
   output logic              out_last,
   output logic              err_word,
   output logic              pkt_par,
   output logic [CW-1:0]     pkt_beats,
   output logic              err_pkt,
`ifdef PARITY_STATS_EN
   input  logic              stats_clr,
   output logic [15:0]       pkt_cnt,
   output logic [15:0]       err_cnt,
`endif
   output logic              err_len
);

   localparam logic [1:0]    S_IDLE    = 2'd0;
   localparam logic [1:0]    S_BUSY    = 2'd1;
   localparam logic [1:0]    S_OVERRUN = 2'd2;
   localparam logic          ODD_BIT   = (ODD_PARITY != 0);
   localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_BEATS);

   // Word parity in the configured sense (even or odd).
   function automatic logic word_par(input logic [DATA_W-1:0] d);
      return (^d) ^ ODD_BIT;
   endfunction

   // Beat counter increment that sticks at MAX_BEATS.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      return (c == MAX_CNT) ? c : c + CW'(1);
   endfunction

   // Packet state (stage p0): FSM, beat count, running parity, error flag.
   logic [1:0]    state_p0;
   logic [CW-1:0] cnt_p0;
   logic          acc_p0;
   logic          err_acc_p0;
   logic          mode_p0;

   // Registered output beat (stage p1).
   logic              vld_p1;
   logic [DATA_W-1:0] data_p1;
   logic              par_p1;
   logic              last_p1;
   logic              err_word_p1;
   logic              pkt_par_p1;
   logic [CW-1:0]     pkt_beats_p1;
   logic              err_pkt_p1;
   logic              err_len_p1;

   logic          accept;
   logic          first;
   logic          beat_mode;
   logic          wp;
   logic          beat_err;
   logic          over;
   logic          acc_nxt;
   logic          err_nxt;
   logic [CW-1:0] cnt_nxt;
   logic [1:0]    state_nxt;

   assign in_ready = !vld_p1 | out_ready;
   assign accept   = in_valid & in_ready;

   // Per-beat decode: effective mode, word parity, error and next packet state.
   always_comb begin
      first     = (state_p0 == S_IDLE);
      beat_mode = first ? mode : mode_p0;
      wp        = word_par(in_data);
      beat_err  = beat_mode & (in_par != wp);
      cnt_nxt   = first ? CW'(1) : sat_inc(cnt_p0);
      over      = (state_p0 == S_OVERRUN) | (!first & (cnt_p0 == MAX_CNT));
      acc_nxt   = (first ? 1'b0 : acc_p0) ^ (^in_data);
      err_nxt   = (first ? 1'b0 : err_acc_p0) | beat_err;
      state_nxt = S_BUSY;
      if (in_last) begin
         state_nxt = S_IDLE;
      end else if (over) begin
         state_nxt = S_OVERRUN;
      end
   end

   // ---- stage p0: packet accumulators, cleared after each last beat ----
   // Track packet state on every accepted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p0   <= S_IDLE;
         cnt_p0     <= '0;
         acc_p0     <= 1'b0;
         err_acc_p0 <= 1'b0;
         mode_p0    <= 1'b0;
      end else if (accept) begin
         state_p0 <= state_nxt;
         mode_p0  <= beat_mode;
         if (in_last) begin
            cnt_p0     <= '0;
            acc_p0     <= 1'b0;
            err_acc_p0 <= 1'b0;
         end else begin
            cnt_p0     <= cnt_nxt;
            acc_p0     <= acc_nxt;
            err_acc_p0 <= err_nxt;
         end
      end
   end

   // ---- stage p1: single registered output beat ----
   // Load a new beat when the slot is free or draining; hold while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1       <= 1'b0;
         data_p1      <= '0;
         par_p1       <= 1'b0;
         last_p1      <= 1'b0;
         err_word_p1  <= 1'b0;
         pkt_par_p1   <= 1'b0;
         pkt_beats_p1 <= '0;
         err_pkt_p1   <= 1'b0;
         err_len_p1   <= 1'b0;
      end else if (in_ready) begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            data_p1      <= in_data;
            par_p1       <= beat_mode ? in_par : wp;
            last_p1      <= in_last;
            err_word_p1  <= beat_err;
            pkt_par_p1   <= in_last & (acc_nxt ^ ODD_BIT);
            pkt_beats_p1 <= in_last ? cnt_nxt : '0;
            err_pkt_p1   <= in_last & err_nxt;
            err_len_p1   <= in_last & over;
         end
      end
   end

   assign out_valid = vld_p1;
   assign out_data  = data_p1;
   assign out_par   = par_p1;
   assign out_last  = last_p1;
   assign err_word  = err_word_p1;
   assign pkt_par   = pkt_par_p1;
   assign pkt_beats = pkt_beats_p1;
   assign err_pkt   = err_pkt_p1;
   assign err_len   = err_len_p1;

`ifdef PARITY_STATS_EN
   // Counter increment that sticks at all-ones.
   function automatic logic [15:0] sat16(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   logic last_fire;
   assign last_fire = vld_p1 & out_ready & last_p1;

   // Count delivered packets and erroneous packets; clear has priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt <= '0;
         err_cnt <= '0;
      end else if (stats_clr) begin
         pkt_cnt <= '0;
         err_cnt <= '0;
      end else if (last_fire) begin
         pkt_cnt <= sat16(pkt_cnt);
         if (err_pkt_p1 | err_len_p1) begin
            err_cnt <= sat16(err_cnt);
         end
      end
   end
`endif

endmodule

// File: tb/tb_stream_parity_unit.sv
// tb_stream_parity_unit: two instances (even/MAX_BEATS=4 and odd/MAX_BEATS=16)
// share one input stream; a packet-level reference model predicts each
// output beat and status, exercised by directed cases and random traffic.
module tb_stream_parity_unit;

   logic       clk;
   logic       rst_n;
   logic       mode;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_par;
   logic       in_last;
   logic       out_ready;

   logic       e_in_ready, e_out_valid, e_out_par, e_out_last, e_err_word;
   logic       e_pkt_par, e_err_pkt, e_err_len;
   logic [7:0] e_out_data;
   logic [2:0] e_pkt_beats;

   logic       o_in_ready, o_out_valid, o_out_par, o_out_last, o_err_word;
   logic       o_pkt_par, o_err_pkt, o_err_len;
   logic [7:0] o_out_data;
   logic [4:0] o_pkt_beats;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       last;
      logic       errw;
      logic       ppar;
      int         beats;
      logic       epkt;
      logic       elen;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   // Packet model state per instance: 0 = even/max 4, 1 = odd/max 16.
   int   n_m[2];
   logic par_m[2];
   logic err_m[2];
   logic mode_m[2];
   logic inpkt_m[2];

   stream_parity_unit #(.DATA_W(8), .ODD_PARITY(0), .MAX_BEATS(4)) u_even (
      .clk(clk), .rst_n(rst_n), .mode(mode),
      .in_valid(in_valid), .in_ready(e_in_ready), .in_data(in_data),
      .in_par(in_par), .in_last(in_last),
      .out_valid(e_out_valid), .out_ready(out_ready), .out_data(e_out_data),
      .out_par(e_out_par), .out_last(e_out_last), .err_word(e_err_word),
      .pkt_par(e_pkt_par), .pkt_beats(e_pkt_beats), .err_pkt(e_err_pkt),
      .err_len(e_err_len)
   );

   stream_parity_unit #(.DATA_W(8), .ODD_PARITY(1), .MAX_BEATS(16)) u_odd (
      .clk(clk), .rst_n(rst_n), .mode(mode),
      .in_valid(in_valid), .in_ready(o_in_ready), .in_data(in_data),
      .in_par(in_par), .in_last(in_last),
      .out_valid(o_out_valid), .out_ready(out_ready), .out_data(o_out_data),
      .out_par(o_out_par), .out_last(o_out_last), .err_word(o_err_word),
      .pkt_par(o_pkt_par), .pkt_beats(o_pkt_beats), .err_pkt(o_err_pkt),
      .err_len(o_err_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: one accepted beat for instance i, computed from packet rules.
   function automatic exp_t model_beat(int i, logic [7:0] d, logic p, logic l, logic md);
      exp_t x;
      logic odd;
      int   maxb;
      logic raw;
      logic wpar;
      odd  = (i == 1);
      maxb = (i == 1) ? 16 : 4;
      if (!inpkt_m[i]) begin
         inpkt_m[i] = 1'b1;
         mode_m[i]  = md;
         n_m[i]     = 0;
         par_m[i]   = 1'b0;
         err_m[i]   = 1'b0;
      end
      n_m[i]++;
      raw      = ($countones(d) % 2) == 1;
      wpar     = raw ^ odd;
      par_m[i] = par_m[i] ^ raw;
      x.data   = d;
      x.last   = l;
      x.par    = mode_m[i] ? p : wpar;
      x.errw   = mode_m[i] && (p != wpar);
      err_m[i] = err_m[i] | x.errw;
      x.ppar   = l ? (par_m[i] ^ odd) : 1'b0;
      x.beats  = l ? ((n_m[i] > maxb) ? maxb : n_m[i]) : 0;
      x.epkt   = l ? err_m[i] : 1'b0;
      x.elen   = l ? (n_m[i] > maxb) : 1'b0;
      if (l) inpkt_m[i] = 1'b0;
      return x;
   endfunction

   task automatic compare_outs();
      check("e_valid", e_out_valid, q0.size() != 0);
      if (q0.size() != 0) begin
         check("e_data", e_out_data, q0[0].data);
         check("e_par", e_out_par, q0[0].par);
         check("e_last", e_out_last, q0[0].last);
         check("e_err_word", e_err_word, q0[0].errw);
         check("e_pkt_par", e_pkt_par, q0[0].ppar);
         check("e_pkt_beats", e_pkt_beats, q0[0].beats);
         check("e_err_pkt", e_err_pkt, q0[0].epkt);
         check("e_err_len", e_err_len, q0[0].elen);
      end
      check("o_valid", o_out_valid, q1.size() != 0);
      if (q1.size() != 0) begin
         check("o_data", o_out_data, q1[0].data);
         check("o_par", o_out_par, q1[0].par);
         check("o_last", o_out_last, q1[0].last);
         check("o_err_word", o_err_word, q1[0].errw);
         check("o_pkt_par", o_pkt_par, q1[0].ppar);
         check("o_pkt_beats", o_pkt_beats, q1[0].beats);
         check("o_err_pkt", o_err_pkt, q1[0].epkt);
         check("o_err_len", o_err_len, q1[0].elen);
      end
   endtask

   task automatic check_reset_outs();
      check("rst_e_valid", e_out_valid, 0);
      check("rst_e_data", e_out_data, 0);
      check("rst_e_par", e_out_par, 0);
      check("rst_e_last", e_out_last, 0);
      check("rst_e_status", {e_err_word, e_pkt_par, e_pkt_beats, e_err_pkt, e_err_len}, 0);
      check("rst_o_valid", o_out_valid, 0);
      check("rst_o_data", o_out_data, 0);
      check("rst_o_par", o_out_par, 0);
      check("rst_o_last", o_out_last, 0);
      check("rst_o_status", {o_err_word, o_pkt_par, o_pkt_beats, o_err_pkt, o_err_len}, 0);
   endtask

   // One clock cycle: compare outputs, drive inputs, advance the model.
   task automatic cycle(input logic iv, input logic [7:0] d, input logic p,
                        input logic l, input logic md, input logic ordy,
                        output logic accepted);
      logic pop;
      logic exp_rdy;
      @(negedge clk);
      compare_outs();
      in_valid  = iv;
      in_data   = d;
      in_par    = p;
      in_last   = l;
      mode      = md;
      out_ready = ordy;
      #1;
      exp_rdy = (q0.size() == 0) || ordy;
      check("e_in_ready", e_in_ready, exp_rdy);
      check("o_in_ready", o_in_ready, exp_rdy);
      accepted = iv && exp_rdy;
      pop      = (q0.size() != 0) && ordy;
      @(posedge clk);
      if (pop) begin
         void'(q0.pop_front());
         if (q1.size() != 0) void'(q1.pop_front());
      end
      if (accepted) begin
         q0.push_back(model_beat(0, d, p, l, md));
         q1.push_back(model_beat(1, d, p, l, md));
      end
   endtask

   task automatic model_clear();
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) inpkt_m[i] = 1'b0;
   endtask

   task automatic reset_mid();
      #3;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check_reset_outs();
      model_clear();
      @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      logic a;
      int   plen;
      int   pos;
      rst_n = 1'b0;
      mode = 1'b0; in_valid = 1'b0; in_data = '0; in_par = 1'b0;
      in_last = 1'b0; out_ready = 1'b1;
      model_clear();
      #2;
      check_reset_outs();
      #10 rst_n = 1'b1;

      // Single-beat packet 8'hA5
      cycle(1, 8'hA5, 0, 1, 0, 1, a); #2;
      check("a5_e_valid", e_out_valid, 1);
      check("a5_e_par", e_out_par, 0);
      check("a5_e_pkt_par", e_pkt_par, 0);
      check("a5_e_beats", e_pkt_beats, 1);
      check("a5_e_errs", {e_err_word, e_err_pkt, e_err_len}, 0);
      check("a5_o_par", o_out_par, 1);

      // Three-beat packet 01,03,07
      cycle(1, 8'h01, 0, 0, 0, 1, a); #2;
      check("p3_b0_e_par", e_out_par, 1);
      check("p3_b0_o_par", o_out_par, 0);
      check("p3_b0_e_pkt_par", e_pkt_par, 0);
      cycle(1, 8'h03, 0, 0, 0, 1, a); #2;
      check("p3_b1_e_par", e_out_par, 0);
      check("p3_b1_o_par", o_out_par, 1);
      cycle(1, 8'h07, 0, 1, 0, 1, a); #2;
      check("p3_b2_e_par", e_out_par, 1);
      check("p3_b2_o_par", o_out_par, 0);
      check("p3_e_pkt_par", e_pkt_par, 0);
      check("p3_o_pkt_par", o_pkt_par, 1);
      check("p3_e_beats", e_pkt_beats, 3);
      check("p3_o_beats", o_pkt_beats, 3);

      // Backpressure: hold out_ready low three cycles
      cycle(1, 8'h3C, 0, 1, 0, 1, a); #2;
      for (int k = 0; k < 3; k++) begin
         cycle(1, 8'h11, 0, 1, 0, 0, a); #2;
         check("stall_data", e_out_data, 8'h3C);
         check("stall_ready", e_in_ready, 0);
         check("stall_valid", e_out_valid, 1);
      end
      cycle(1, 8'h11, 0, 1, 0, 1, a); #2;
      check("release_data", e_out_data, 8'h11);
      cycle(0, 8'h00, 0, 0, 0, 1, a);

      // Check mode: 0F/par1 then 01/par1 last (mode flip ignored)
      cycle(1, 8'h0F, 1, 0, 1, 1, a); #2;
      check("chk_e_err0", e_err_word, 1);
      check("chk_o_err0", o_err_word, 0);
      check("chk_e_par0", e_out_par, 1);
      cycle(1, 8'h01, 1, 1, 0, 1, a); #2;
      check("chk_e_err1", e_err_word, 0);
      check("chk_o_err1", o_err_word, 1);
      check("chk_e_err_pkt", e_err_pkt, 1);
      check("chk_o_err_pkt", o_err_pkt, 1);

      // Overrun: 6 beats against MAX_BEATS=4, then a 2-beat packet
      for (int k = 0; k < 6; k++) cycle(1, 8'(k + 1), 0, k == 5, 0, 1, a);
      #2;
      check("ovr_e_beats", e_pkt_beats, 4);
      check("ovr_e_err_len", e_err_len, 1);
      check("ovr_o_beats", o_pkt_beats, 6);
      check("ovr_o_err_len", o_err_len, 0);
      cycle(1, 8'h21, 0, 0, 0, 1, a);
      cycle(1, 8'h22, 0, 1, 0, 1, a); #2;
      check("post_e_beats", e_pkt_beats, 2);
      check("post_e_err_len", e_err_len, 0);

      // Reset in the middle of a packet
      cycle(1, 8'hAA, 0, 0, 0, 1, a);
      cycle(1, 8'h55, 0, 0, 0, 1, a);
      reset_mid();
      cycle(1, 8'hC3, 0, 1, 0, 1, a); #2;
      check("rst_new_e_valid", e_out_valid, 1);
      check("rst_new_e_beats", e_pkt_beats, 1);
      check("rst_new_o_beats", o_pkt_beats, 1);
      cycle(0, 8'h00, 0, 0, 0, 1, a);

      // Random traffic with random backpressure and packet lengths up to 20
      plen = $urandom_range(1, 20);
      pos  = 0;
      for (int k = 0; k < 3000; k++) begin
         cycle($urandom_range(0, 9) < 7, 8'($urandom), 1'($urandom),
               pos == plen - 1, 1'($urandom), $urandom_range(0, 9) < 7, a);
         if (a) begin
            pos++;
            if (pos == plen) begin
               pos  = 0;
               plen = $urandom_range(1, 20);
            end
         end
      end
      for (int k = 0; k < 4; k++) cycle(0, 8'h00, 0, 0, 0, 1, a);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
